// File: rtl/alu_ctrl_seq_pkg.sv
//==============================================================================
// Module : alu_ctrl_seq_pkg
// Brief  : Opcode / ALU-control encodings and sequencer states for alu_ctrl_seq.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package alu_ctrl_seq_pkg;

    localparam int ALU_OP_W    = 5;
    localparam int ALU_CTRL_W  = 3;
    localparam int ALU_SHAMT_W = 3;

    // Instruction opcodes
    localparam logic [ALU_OP_W-1:0] ADD_OP   = 5'd0;
    localparam logic [ALU_OP_W-1:0] SUB_OP   = 5'd1;
    localparam logic [ALU_OP_W-1:0] AND_OP   = 5'd2;
    localparam logic [ALU_OP_W-1:0] OR_OP    = 5'd3;
    localparam logic [ALU_OP_W-1:0] NOR_OP   = 5'd4;
    localparam logic [ALU_OP_W-1:0] SLT_OP   = 5'd5;
    localparam logic [ALU_OP_W-1:0] SLL_OP   = 5'd6;
    localparam logic [ALU_OP_W-1:0] SRL_OP   = 5'd7;
    localparam logic [ALU_OP_W-1:0] ADDI_OP  = 5'd8;
    localparam logic [ALU_OP_W-1:0] ANDI_OP  = 5'd9;
    localparam logic [ALU_OP_W-1:0] ORI_OP   = 5'd10;
    localparam logic [ALU_OP_W-1:0] NORI_OP  = 5'd11;
    localparam logic [ALU_OP_W-1:0] SLTI_OP  = 5'd12;
    localparam logic [ALU_OP_W-1:0] SLLI_OP  = 5'd13;
    localparam logic [ALU_OP_W-1:0] SRLI_OP  = 5'd14;
    localparam logic [ALU_OP_W-1:0] LOAD_OP  = 5'd15;
    localparam logic [ALU_OP_W-1:0] STORE_OP = 5'd16;
    localparam logic [ALU_OP_W-1:0] BEQ_OP   = 5'd17;
    localparam logic [ALU_OP_W-1:0] BNE_OP   = 5'd18;
    localparam logic [ALU_OP_W-1:0] J_OP     = 5'd19;

    // ALU control codes
    localparam logic [ALU_CTRL_W-1:0] ADD_ALU = 3'd0;
    localparam logic [ALU_CTRL_W-1:0] SUB_ALU = 3'd1;
    localparam logic [ALU_CTRL_W-1:0] AND_ALU = 3'd2;
    localparam logic [ALU_CTRL_W-1:0] OR_ALU  = 3'd3;
    localparam logic [ALU_CTRL_W-1:0] NOR_ALU = 3'd4;
    localparam logic [ALU_CTRL_W-1:0] SLT_ALU = 3'd5;
    localparam logic [ALU_CTRL_W-1:0] SLL_ALU = 3'd6;
    localparam logic [ALU_CTRL_W-1:0] SRL_ALU = 3'd7;

    typedef enum logic [0:0] {
        ALU_CTRL_IDLE  = 1'b0,
        ALU_CTRL_SHIFT = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_seq_if.sv
//==============================================================================
// Module : alu_ctrl_seq_if
// Brief  : Decode-side and ALU-side handshake bundle of the ALU control unit.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface alu_ctrl_seq_if
    import alu_ctrl_seq_pkg::*;
#(
    parameter int OP_W    = ALU_OP_W,
    parameter int CTRL_W  = ALU_CTRL_W,
    parameter int SHAMT_W = ALU_SHAMT_W
);
    logic               in_valid;
    logic               in_ready;
    logic [OP_W-1:0]    opcode;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [CTRL_W-1:0]  alu_ctrl;
    logic [SHAMT_W-1:0] step_amt;
    logic               last;
    logic               illegal;

    // Environment side: drives the instruction and consumes beats
    modport master (
        output in_valid, opcode, shamt, out_ready,
        input  in_ready, out_valid, alu_ctrl, step_amt, last, illegal
    );

    // Control unit side
    modport slave (
        input  in_valid, opcode, shamt, out_ready,
        output in_ready, out_valid, alu_ctrl, step_amt, last, illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_ctrl_seq_decode.sv
//==============================================================================
// Module : alu_op_decode
// Brief  : Combinational opcode -> ALU control mapping; unknown codes map to
//          ADD_ALU with legal=0.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module alu_op_decode
    import alu_ctrl_seq_pkg::*;
#(
    parameter int OP_W   = ALU_OP_W,
    parameter int CTRL_W = ALU_CTRL_W
) (
    input  logic [OP_W-1:0]   opcode,
    output logic [CTRL_W-1:0] ctrl,
    output logic              legal
);
    always_comb begin
        ctrl  = ADD_ALU;
        legal = 1'b1;
        case (opcode)
            ADD_OP, ADDI_OP, LOAD_OP, STORE_OP: ctrl = ADD_ALU;
            SUB_OP, BEQ_OP, BNE_OP, J_OP:       ctrl = SUB_ALU;
            SLT_OP, SLTI_OP:                    ctrl = SLT_ALU;
            AND_OP, ANDI_OP:                    ctrl = AND_ALU;
            OR_OP, ORI_OP:                      ctrl = OR_ALU;
            NOR_OP, NORI_OP:                    ctrl = NOR_ALU;
            SLL_OP, SLLI_OP:                    ctrl = SLL_ALU;
            SRL_OP, SRLI_OP:                    ctrl = SRL_ALU;
            default:                            legal = 1'b0;
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
//==============================================================================
// Module : alu_ctrl_seq
// Brief  : Registered, handshaked ALU control sequencer; splits shifts into
//          beats of at most SHIFT_STEP bits. Optional sticky illegal-opcode
//          flag under macro ALU_CTRL_ILLEGAL_TRAP_EN.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module alu_ctrl_seq
    import alu_ctrl_seq_pkg::*;
#(
    parameter int OP_W       = ALU_OP_W,
    parameter int CTRL_W     = ALU_CTRL_W,
    parameter int SHAMT_W    = ALU_SHAMT_W,
    parameter int SHIFT_STEP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_ctrl_seq_if.slave bus
);
    localparam logic [SHAMT_W-1:0] c_step = SHAMT_W'(SHIFT_STEP);

    state_t             r_state, w_state_n;
    logic [SHAMT_W-1:0] r_rem, w_rem_n;
    logic               r_out_valid, w_out_valid_n;
    logic [CTRL_W-1:0]  r_alu_ctrl, w_alu_ctrl_n;
    logic [SHAMT_W-1:0] r_step_amt, w_step_amt_n;
    logic               r_last, w_last_n;

    logic [CTRL_W-1:0]  w_dec_ctrl;
    logic               w_dec_legal;
    logic [CTRL_W-1:0]  w_issue_ctrl;
    logic               w_is_shift;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_consume;
    logic [SHAMT_W-1:0] w_rem_step;

    alu_op_decode #(
        .OP_W   (OP_W),
        .CTRL_W (CTRL_W)
    ) u_decode (
        .opcode (bus.opcode),
        .ctrl   (w_dec_ctrl),
        .legal  (w_dec_legal)
    );

    // Illegal opcodes always issue as a single ADD nop
    assign w_issue_ctrl = w_dec_legal ? w_dec_ctrl : ADD_ALU;
    assign w_is_shift   = w_dec_legal && (w_dec_ctrl == SLL_ALU || w_dec_ctrl == SRL_ALU);

    assign w_in_ready = (r_state == ALU_CTRL_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_consume  = r_out_valid && bus.out_ready;
    assign w_rem_step = (r_rem < c_step) ? r_rem : c_step;

    always_comb begin
        w_state_n     = r_state;
        w_rem_n       = r_rem;
        w_out_valid_n = r_out_valid;
        w_alu_ctrl_n  = r_alu_ctrl;
        w_step_amt_n  = r_step_amt;
        w_last_n      = r_last;
        case (r_state)
            ALU_CTRL_IDLE: begin
                if (w_accept) begin
                    w_out_valid_n = 1'b1;
                    w_alu_ctrl_n  = w_issue_ctrl;
                    if (w_is_shift && (bus.shamt > c_step)) begin
                        w_step_amt_n = c_step;
                        w_last_n     = 1'b0;
                        w_rem_n      = bus.shamt - c_step;
                        w_state_n    = ALU_CTRL_SHIFT;
                    end else begin
                        w_step_amt_n = w_is_shift ? bus.shamt : '0;
                        w_last_n     = 1'b1;
                        w_rem_n      = '0;
                    end
                end else if (w_consume) begin
                    w_out_valid_n = 1'b0;
                end
            end
            ALU_CTRL_SHIFT: begin
                if (w_consume) begin
                    if (r_last) begin
                        w_state_n     = ALU_CTRL_IDLE;
                        w_out_valid_n = 1'b0;
                    end else begin
                        w_step_amt_n = w_rem_step;
                        w_rem_n      = r_rem - w_rem_step;
                        w_last_n     = (r_rem == w_rem_step);
                    end
                end
            end
            default: w_state_n = ALU_CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ALU_CTRL_IDLE;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_alu_ctrl  <= ADD_ALU;
            r_step_amt  <= '0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_rem       <= w_rem_n;
            r_out_valid <= w_out_valid_n;
            r_alu_ctrl  <= w_alu_ctrl_n;
            r_step_amt  <= w_step_amt_n;
            r_last      <= w_last_n;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_accept && !w_dec_legal) begin
            r_illegal <= 1'b1;
        end
    end

    assign bus.illegal = r_illegal;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.alu_ctrl  = r_alu_ctrl;
    assign bus.step_amt  = r_step_amt;
    assign bus.last      = r_last;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
//==============================================================================
// Module : tb_alu_ctrl_seq
// Brief  : Directed self-checking bench; one unit with SHIFT_STEP=1 and one
//          with SHIFT_STEP=2 share clock and reset.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_alu_ctrl_seq;
    import alu_ctrl_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam logic c_ill_exp = 1'b1;
`else
    localparam logic c_ill_exp = 1'b0;
`endif

    alu_ctrl_seq_if bus1 ();
    alu_ctrl_seq_if bus2 ();

    alu_ctrl_seq #(.SHIFT_STEP(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    alu_ctrl_seq #(.SHIFT_STEP(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat1(input string tag, input logic ov, input logic [2:0] ctrl,
                         input logic [2:0] step, input logic lst);
        check({tag, ".valid"}, 8'(bus1.out_valid), 8'(ov));
        check({tag, ".ctrl"},  8'(bus1.alu_ctrl),  8'(ctrl));
        check({tag, ".step"},  8'(bus1.step_amt),  8'(step));
        check({tag, ".last"},  8'(bus1.last),      8'(lst));
    endtask

    task automatic beat2(input string tag, input logic ov, input logic [2:0] ctrl,
                         input logic [2:0] step, input logic lst);
        check({tag, ".valid"}, 8'(bus2.out_valid), 8'(ov));
        check({tag, ".ctrl"},  8'(bus2.alu_ctrl),  8'(ctrl));
        check({tag, ".step"},  8'(bus2.step_amt),  8'(step));
        check({tag, ".last"},  8'(bus2.last),      8'(lst));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus1.in_valid = 1'b0; bus1.opcode = '0; bus1.shamt = '0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.opcode = '0; bus2.shamt = '0; bus2.out_ready = 1'b0;
        tick();
        tick();
        beat1("rst", 1'b0, ADD_ALU, 3'd0, 1'b0);
        check("rst.illegal", 8'(bus1.illegal), 8'd0);
        check("rst.in_ready", 8'(bus1.in_ready), 8'd1);
        rst_n = 1'b1;
        tick();

        // Back-to-back single-beat ops
        bus1.out_ready = 1'b1;
        bus1.in_valid  = 1'b1;
        bus1.opcode    = ADD_OP;
        tick();
        beat1("b2b.add", 1'b1, ADD_ALU, 3'd0, 1'b1);
        check("b2b.add.in_ready", 8'(bus1.in_ready), 8'd1);
        bus1.opcode = SUB_OP;
        tick();
        beat1("b2b.sub", 1'b1, SUB_ALU, 3'd0, 1'b1);
        bus1.opcode = BEQ_OP;
        tick();
        beat1("b2b.beq", 1'b1, SUB_ALU, 3'd0, 1'b1);
        bus1.opcode = LOAD_OP;
        tick();
        beat1("b2b.load", 1'b1, ADD_ALU, 3'd0, 1'b1);
        bus1.in_valid = 1'b0;
        tick();
        check("b2b.drain", 8'(bus1.out_valid), 8'd0);

        // SLLI shamt=3, step 1, with a 3-cycle stall on beat 2
        bus1.in_valid = 1'b1;
        bus1.opcode   = SLLI_OP;
        bus1.shamt    = 3'd3;
        tick();
        bus1.in_valid = 1'b0;
        beat1("slli.b1", 1'b1, SLL_ALU, 3'd1, 1'b0);
        check("slli.b1.in_ready", 8'(bus1.in_ready), 8'd0);
        tick();
        beat1("slli.b2", 1'b1, SLL_ALU, 3'd1, 1'b0);
        bus1.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            beat1("slli.stall", 1'b1, SLL_ALU, 3'd1, 1'b0);
            check("slli.stall.in_ready", 8'(bus1.in_ready), 8'd0);
        end
        bus1.out_ready = 1'b1;
        tick();
        beat1("slli.b3", 1'b1, SLL_ALU, 3'd1, 1'b1);
        check("slli.b3.in_ready", 8'(bus1.in_ready), 8'd0);
        tick();
        check("slli.done.valid", 8'(bus1.out_valid), 8'd0);
        check("slli.done.in_ready", 8'(bus1.in_ready), 8'd1);

        // SRL shamt=5 with step 2 -> 2,2,1
        bus2.out_ready = 1'b1;
        bus2.in_valid  = 1'b1;
        bus2.opcode    = SRL_OP;
        bus2.shamt     = 3'd5;
        tick();
        bus2.in_valid = 1'b0;
        beat2("srl.b1", 1'b1, SRL_ALU, 3'd2, 1'b0);
        tick();
        beat2("srl.b2", 1'b1, SRL_ALU, 3'd2, 1'b0);
        tick();
        beat2("srl.b3", 1'b1, SRL_ALU, 3'd1, 1'b1);
        tick();
        check("srl.done.valid", 8'(bus2.out_valid), 8'd0);

        // shamt=0 and shamt==SHIFT_STEP are both single beats
        bus2.in_valid = 1'b1;
        bus2.opcode   = SRL_OP;
        bus2.shamt    = 3'd0;
        tick();
        beat2("srl0", 1'b1, SRL_ALU, 3'd0, 1'b1);
        bus2.opcode = SLL_OP;
        bus2.shamt  = 3'd2;
        tick();
        beat2("sll2", 1'b1, SLL_ALU, 3'd2, 1'b1);
        bus2.opcode = ANDI_OP;
        bus2.shamt  = 3'd7;
        tick();
        beat2("andi", 1'b1, AND_ALU, 3'd0, 1'b1);
        bus2.in_valid = 1'b0;
        tick();

        // Illegal opcode, then a legal op: flag is sticky when trapping
        bus1.in_valid = 1'b1;
        bus1.opcode   = 5'h1F;
        bus1.shamt    = 3'd0;
        tick();
        beat1("ill", 1'b1, ADD_ALU, 3'd0, 1'b1);
        check("ill.flag", 8'(bus1.illegal), 8'(c_ill_exp));
        bus1.opcode = ORI_OP;
        tick();
        beat1("ill.ori", 1'b1, OR_ALU, 3'd0, 1'b1);
        check("ill.sticky", 8'(bus1.illegal), 8'(c_ill_exp));
        bus1.opcode = NOR_OP;
        tick();
        beat1("nor", 1'b1, NOR_ALU, 3'd0, 1'b1);
        bus1.opcode = SLT_OP;
        tick();
        beat1("slt", 1'b1, SLT_ALU, 3'd0, 1'b1);

        // Reset in the middle of a shift drops it
        bus1.opcode = SLLI_OP;
        bus1.shamt  = 3'd7;
        tick();
        bus1.in_valid = 1'b0;
        beat1("rstmid.b1", 1'b1, SLL_ALU, 3'd1, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        beat1("rstmid", 1'b0, ADD_ALU, 3'd0, 1'b0);
        check("rstmid.illegal", 8'(bus1.illegal), 8'd0);
        check("rstmid.in_ready", 8'(bus1.in_ready), 8'd1);
        rst_n = 1'b1;
        tick();
        check("rstmid.after", 8'(bus1.out_valid), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
